// File: rtl/lc3b_ir_fetch.sv
// LC-3b instruction fetch stage: PC register, single-outstanding memory read,
// instruction register and raw (unextended) operand field slices.
module lc3b_ir_fetch #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        ir_valid,
  input  logic        ir_ack,
  output logic [15:0] pc_out,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [2:0]  dest,
  output logic [2:0]  src1,
  output logic [2:0]  src2,
  output logic [4:0]  imm5,
  output logic [5:0]  offset6,
  output logic [7:0]  trapvect8,
  output logic [8:0]  offset9,
  output logic [10:0] offset11
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] ir_q, ir_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= PC_RESET;
      ir_q  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir_q  <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir_q;
    case (state)
      IDLE: begin
        // A simultaneous load and start fetches from the newly loaded PC.
        if (pc_load) pc_next = pc_in & 16'hFFFE;
        if (start)   state_next = FETCH;
      end
      FETCH: begin
        if (mem_resp) begin
          ir_next    = mem_rdata;
          pc_next    = pc + 16'd2;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (pc_load) pc_next = pc_in & 16'hFFFE;
        if (ir_ack)  state_next = start ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode purely from the state register: no input-to-output path.
  assign mem_read    = (state == FETCH);
  assign ir_valid    = (state == HOLD);
  assign mem_address = pc;
  assign pc_out      = pc;
  assign ir          = ir_q;

  assign opcode    = ir_q[15:12];
  assign dest      = ir_q[11:9];
  assign src1      = ir_q[8:6];
  assign src2      = ir_q[2:0];
  assign imm5      = ir_q[4:0];
  assign offset6   = ir_q[5:0];
  assign trapvect8 = ir_q[7:0];
  assign offset9   = ir_q[8:0];
  assign offset11  = ir_q[10:0];

endmodule
